i2c_bus_arbiter: RTL and testbench
==================================

// Module: i2c_bus_arbiter
// PURPOSE
//   Shares the single i2c_controller between NUM_REQ register-write requesters
//   (HDMI TX init sequencer, audio codec config, status poller).
//   Grants round-robin, latches the winner's dev_addr/reg_data and drives the
//   controller's start/ready handshake. Returns a per-requester done pulse with ACK status.
//   Runs on the divided I2C clock, the same clock as the controller.
// PARAMETERS
//   NUM_REQ         3    number of requesters (2..8)
//   TIMEOUT_CYCLES  64   watchdog limit in clk cycles (used only with I2C_ARB_TIMEOUT_EN)
// PORTS
//   clk           in   1           I2C-domain clock
//   reset         in   1           reset, synchronous, active-high
//   req           in   NUM_REQ     level request, one bit per requester
//   req_dev_addr  in   8*NUM_REQ   8-bit write address per requester, requester i at [8i+7:8i]
//   req_reg_data  in   16*NUM_REQ  {reg,data} per requester, requester i at [16i+15:16i]
//   grant         out  NUM_REQ     one-hot owner, all zero when idle
//   done          out  NUM_REQ     1-cycle completion pulse to the owner
//   ack_out       out  1           device ACKed all bytes; valid from done, held until next done
//   err_out       out  1           watchdog abort; held like ack_out; constant 0 without macro
//   busy          out  1           high from grant through RELEASE
//   ctl_start     out  1           start level to controller
//   ctl_dev_addr  out  8           latched address to controller
//   ctl_reg_data  out  16          latched {reg,data} to controller
//   ctl_ready     in   1           controller idle/finished
//   ctl_ack       in   1           controller ACK result, sampled on ctl_ready rise
// BEHAVIOUR
//   Reset: all outputs 0. State IDLE. RR pointer last=NUM_REQ-1, so requester 0 has top priority.
//     Reset mid-transaction aborts silently, with no done pulse. The controller shares the reset.
//   FSM (registered outputs):
//     IDLE      : if ctl_ready && |req: winner = first set bit searching from last+1 (wrapping);
//                 grant<=onehot(winner); latch addr/data; -> LAUNCH. Else stay.
//     LAUNCH    : ctl_start<=1; -> WAIT_BUSY
//     WAIT_BUSY : hold ctl_start=1 until ctl_ready==0, then ctl_start<=0; -> WAIT_DONE
//     WAIT_DONE : on ctl_ready==1: ack_out<=ctl_ack, err_out<=0, done[winner]<=1; -> RELEASE
//     RELEASE   : done<=0, grant<=0, last<=winner; -> IDLE
//   Latency: req sampled in IDLE -> grant next cycle -> ctl_start the cycle after.
//   Minimum transaction is 5 cycles plus the controller's busy time.
//   Latched addr/data are immune to requester changes after grant.
//   Dropping req after grant does not cancel; done still pulses.
//   Requester must drop req on done. A req still high in IDLE re-arbitrates; the RR pointer
//     guarantees others are served first when they are pending.
//   NACK is not retried; policy is left to the requester.
//   ctl_ready low in IDLE blocks arbitration; pending reqs wait.
// CONFIGURATION
//   `I2C_ARB_TIMEOUT_EN defined: watchdog counter cleared in LAUNCH, incremented in
//     WAIT_BUSY/WAIT_DONE. Reaching TIMEOUT_CYCLES forces ctl_start<=0, done[winner]<=1,
//     ack_out<=0, err_out<=1, -> RELEASE. IDLE's ctl_ready gate keeps the stuck controller out.
//   Undefined: no counter, WAIT_* wait indefinitely, err_out tied 0.
// STRUCTURE
//   i2c_arb_pkg: state encodings (IDLE..RELEASE), ADDR_W=8, DATA_W=16, default NUM_REQ.
//   Sub-module rr_priority_picker: combinational (req, last) -> one-hot winner + index.
//   Arbiter keeps FSM, latches and watchdog.
// TESTING (controller modelled as BFM: ready drops 2 cycles after start, rises N cycles later)
//   1. req=001, addr0=0x72, data0=0x9803, N=20 -> grant=001 next cycle; ctl_dev_addr=0x72,
//      ctl_reg_data=0x9803; ctl_start high until ready falls; done=001 for 1 cycle; ack_out=1.
//   2. req=111 held continuously from reset -> grant order 001,010,100,001; one done per grant.
//   3. BFM returns ack=0 -> done pulse with ack_out=0, err_out=0; next request proceeds normally.
//   4. Change data0 to 0x1470 one cycle after grant -> ctl_reg_data stays 0x9803 until RELEASE.
//   5. Assert reset in WAIT_DONE -> next cycle grant=0, done=0, ctl_start=0, busy=0.
//      Then req=011 -> requester 0 granted first.
//   6. Macro on, TIMEOUT_CYCLES=64, BFM holds ready low -> done pulse 64 cycles after LAUNCH
//      with err_out=1, ack_out=0. Macro off -> no done; busy stays 1.

Source files
------------

// File: rtl/i2c_arb_pkg.sv
// Shared types and constants for the I2C bus arbiter: FSM state encoding,
// address/data widths and the default requester count.
package i2c_arb_pkg;

    localparam int ADDR_W             = 8;
    localparam int DATA_W             = 16;
    localparam int DEF_NUM_REQ        = 3;
    localparam int DEF_TIMEOUT_CYCLES = 64;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_LAUNCH    = 3'd1,
        ST_WAIT_BUSY = 3'd2,
        ST_WAIT_DONE = 3'd3,
        ST_RELEASE   = 3'd4
    } arb_state_e;

    // Width of a requester index; at least one bit even for degenerate counts.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/i2c_bus_arbiter_rr_priority_picker.sv
// Combinational round-robin picker: the first set request bit found when
// searching upward from last+1, wrapping, as one-hot plus index.
module rr_priority_picker
    import i2c_arb_pkg::*;
#(
    parameter int NUM_REQ = DEF_NUM_REQ,
    parameter int IDX_W   = idx_width(DEF_NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   last,
    output logic [NUM_REQ-1:0] winner_onehot,
    output logic [IDX_W-1:0]   winner_idx,
    output logic               valid
);

    logic [IDX_W-1:0] cand_s;
    logic             hit_s;

    // Walk the candidates in rotated priority order; the first hit sticks.
    always_comb begin
        winner_onehot = '0;
        winner_idx    = '0;
        valid         = 1'b0;
        cand_s        = '0;
        hit_s         = 1'b0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            cand_s                = IDX_W'((int'(last) + k) % NUM_REQ);
            hit_s                 = !valid && req[cand_s];
            winner_onehot[cand_s] = winner_onehot[cand_s] | hit_s;
            winner_idx            = hit_s ? cand_s : winner_idx;
            valid                 = valid | hit_s;
        end
    end

endmodule

// File: rtl/i2c_bus_arbiter.sv
// Round-robin arbiter sharing one I2C controller between NUM_REQ register-write
// requesters. Optional watchdog abort is enabled by defining I2C_ARB_TIMEOUT_EN.
module i2c_bus_arbiter
    import i2c_arb_pkg::*;
#(
    parameter int NUM_REQ        = DEF_NUM_REQ,
    parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [NUM_REQ-1:0]       req,
    input  logic [ADDR_W*NUM_REQ-1:0] req_dev_addr,
    input  logic [DATA_W*NUM_REQ-1:0] req_reg_data,
    output logic [NUM_REQ-1:0]       grant,
    output logic [NUM_REQ-1:0]       done,
    output logic                     ack_out,
    output logic                     err_out,
    output logic                     busy,
    output logic                     ctl_start,
    output logic [ADDR_W-1:0]        ctl_dev_addr,
    output logic [DATA_W-1:0]        ctl_reg_data,
    input  logic                     ctl_ready,
    input  logic                     ctl_ack
);

    localparam int IDX_W = idx_width(NUM_REQ);

    arb_state_e          state_r, state_nxt_s;
    logic [NUM_REQ-1:0]  grant_r, grant_nxt_s;
    logic [NUM_REQ-1:0]  done_r, done_nxt_s;
    logic                ack_r, ack_nxt_s;
    logic                busy_r, busy_nxt_s;
    logic                start_r, start_nxt_s;
    logic [ADDR_W-1:0]   addr_r, addr_nxt_s;
    logic [DATA_W-1:0]   data_r, data_nxt_s;
    logic [IDX_W-1:0]    winner_r, winner_nxt_s;
    logic [IDX_W-1:0]    last_r, last_nxt_s;

    logic [NUM_REQ-1:0]  pick_onehot_s;
    logic [IDX_W-1:0]    pick_idx_s;
    logic                pick_valid_s;
    logic                arb_go_s;
    logic                timeout_s;

    rr_priority_picker #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_picker (
        .req           (req),
        .last          (last_r),
        .winner_onehot (pick_onehot_s),
        .winner_idx    (pick_idx_s),
        .valid         (pick_valid_s)
    );

    // A busy controller keeps everyone waiting, including after a watchdog abort.
    assign arb_go_s = ctl_ready && pick_valid_s;

`ifdef I2C_ARB_TIMEOUT_EN
    localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [WD_W-1:0] wd_cnt_r;
    logic            err_r, err_nxt_s;
    logic            waiting_s;

    assign waiting_s = (state_r == ST_WAIT_BUSY) || (state_r == ST_WAIT_DONE);
    assign timeout_s = waiting_s && (wd_cnt_r == WD_W'(TIMEOUT_CYCLES - 1));

    // Watchdog counter: cleared on launch, counts every cycle spent waiting.
    always_ff @(posedge clk) begin
        if (reset) begin
            wd_cnt_r <= '0;
        end else if (state_r == ST_LAUNCH) begin
            wd_cnt_r <= '0;
        end else if (waiting_s && !timeout_s) begin
            wd_cnt_r <= wd_cnt_r + 1'b1;
        end else begin
            wd_cnt_r <= wd_cnt_r;
        end
    end

    // Error flag: set by an abort, cleared by a normal completion, else held.
    always_comb begin
        err_nxt_s = err_r;
        if (timeout_s) begin
            err_nxt_s = 1'b1;
        end else if ((state_r == ST_WAIT_DONE) && ctl_ready) begin
            err_nxt_s = 1'b0;
        end else begin
            err_nxt_s = err_r;
        end
    end

    // Error flag register.
    always_ff @(posedge clk) begin
        if (reset) begin
            err_r <= 1'b0;
        end else begin
            err_r <= err_nxt_s;
        end
    end

    assign err_out = err_r;
`else
    assign timeout_s = 1'b0;
    assign err_out   = 1'b0;
`endif

    // FSM state register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // FSM next-state logic.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE:      state_nxt_s = arb_go_s ? ST_LAUNCH : ST_IDLE;
            ST_LAUNCH:    state_nxt_s = ST_WAIT_BUSY;
            ST_WAIT_BUSY: begin
                if (timeout_s) begin
                    state_nxt_s = ST_RELEASE;
                end else if (!ctl_ready) begin
                    state_nxt_s = ST_WAIT_DONE;
                end else begin
                    state_nxt_s = ST_WAIT_BUSY;
                end
            end
            ST_WAIT_DONE: begin
                if (timeout_s || ctl_ready) begin
                    state_nxt_s = ST_RELEASE;
                end else begin
                    state_nxt_s = ST_WAIT_DONE;
                end
            end
            ST_RELEASE:   state_nxt_s = ST_IDLE;
            default:      state_nxt_s = ST_IDLE;
        endcase
    end

    // FSM output logic: next values of every registered output and latch.
    always_comb begin
        grant_nxt_s  = grant_r;
        done_nxt_s   = done_r;
        ack_nxt_s    = ack_r;
        busy_nxt_s   = busy_r;
        start_nxt_s  = start_r;
        addr_nxt_s   = addr_r;
        data_nxt_s   = data_r;
        winner_nxt_s = winner_r;
        last_nxt_s   = last_r;
        case (state_r)
            ST_IDLE: begin
                if (arb_go_s) begin
                    grant_nxt_s  = pick_onehot_s;
                    busy_nxt_s   = 1'b1;
                    winner_nxt_s = pick_idx_s;
                    addr_nxt_s   = req_dev_addr[ADDR_W*pick_idx_s +: ADDR_W];
                    data_nxt_s   = req_reg_data[DATA_W*pick_idx_s +: DATA_W];
                end else begin
                    grant_nxt_s  = '0;
                    busy_nxt_s   = 1'b0;
                end
            end
            ST_LAUNCH: begin
                start_nxt_s = 1'b1;
            end
            ST_WAIT_BUSY: begin
                if (timeout_s) begin
                    start_nxt_s = 1'b0;
                    done_nxt_s  = grant_r;
                    ack_nxt_s   = 1'b0;
                end else if (!ctl_ready) begin
                    start_nxt_s = 1'b0;
                end else begin
                    start_nxt_s = 1'b1;
                end
            end
            ST_WAIT_DONE: begin
                if (timeout_s) begin
                    done_nxt_s = grant_r;
                    ack_nxt_s  = 1'b0;
                end else if (ctl_ready) begin
                    done_nxt_s = grant_r;
                    ack_nxt_s  = ctl_ack;
                end else begin
                    done_nxt_s = '0;
                end
            end
            ST_RELEASE: begin
                done_nxt_s  = '0;
                grant_nxt_s = '0;
                busy_nxt_s  = 1'b0;
                last_nxt_s  = winner_r;
            end
            default: begin
                grant_nxt_s = '0;
                done_nxt_s  = '0;
                busy_nxt_s  = 1'b0;
                start_nxt_s = 1'b0;
            end
        endcase
    end

    // Output and latch registers; the pointer resets so requester 0 goes first.
    always_ff @(posedge clk) begin
        if (reset) begin
            grant_r  <= '0;
            done_r   <= '0;
            ack_r    <= 1'b0;
            busy_r   <= 1'b0;
            start_r  <= 1'b0;
            addr_r   <= '0;
            data_r   <= '0;
            winner_r <= '0;
            last_r   <= IDX_W'(NUM_REQ - 1);
        end else begin
            grant_r  <= grant_nxt_s;
            done_r   <= done_nxt_s;
            ack_r    <= ack_nxt_s;
            busy_r   <= busy_nxt_s;
            start_r  <= start_nxt_s;
            addr_r   <= addr_nxt_s;
            data_r   <= data_nxt_s;
            winner_r <= winner_nxt_s;
            last_r   <= last_nxt_s;
        end
    end

    assign grant        = grant_r;
    assign done         = done_r;
    assign ack_out      = ack_r;
    assign busy         = busy_r;
    assign ctl_start    = start_r;
    assign ctl_dev_addr = addr_r;
    assign ctl_reg_data = data_r;

endmodule

// File: tb/tb_i2c_bus_arbiter.sv
// Bench for i2c_bus_arbiter: controller BFM, transaction-level reference model,
// a directed vector table, hand-written corner sequences and random traffic.
module tb_i2c_bus_arbiter;

    localparam int N  = 3;
    localparam int TO = 64;
`ifdef I2C_ARB_TIMEOUT_EN
    localparam bit WD_EN = 1'b1;
`else
    localparam bit WD_EN = 1'b0;
`endif

    logic            clk, reset;
    logic [N-1:0]    req;
    logic [8*N-1:0]  req_dev_addr;
    logic [16*N-1:0] req_reg_data;
    logic [N-1:0]    grant, done;
    logic            ack_out, err_out, busy, ctl_start;
    logic [7:0]      ctl_dev_addr;
    logic [15:0]     ctl_reg_data;
    logic            ctl_ready, ctl_ack;

    int vectors     = 0;
    int miscompares = 0;

    i2c_bus_arbiter #(.NUM_REQ(N), .TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .reset(reset), .req(req), .req_dev_addr(req_dev_addr),
        .req_reg_data(req_reg_data), .grant(grant), .done(done), .ack_out(ack_out),
        .err_out(err_out), .busy(busy), .ctl_start(ctl_start), .ctl_dev_addr(ctl_dev_addr),
        .ctl_reg_data(ctl_reg_data), .ctl_ready(ctl_ready), .ctl_ack(ctl_ack)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Round-robin rule: first set bit searching upward from last+1, wrapping.
    function automatic int rr_pick(input logic [N-1:0] r, input int last);
        for (int k = 1; k <= N; k++) begin
            int c;
            c = (last + k) % N;
            if (r[c]) return c;
        end
        return -1;
    endfunction

    // Controller BFM: ready drops 2 cycles after start is seen, rises n cycles later.
    logic bfm_active, bfm_stuck, bfm_ack, bfm_ack_lat;
    int   bfm_cnt, bfm_n, bfm_n_lat;
    always @(posedge clk) begin
        if (reset) begin
            ctl_ready  <= 1'b1;
            ctl_ack    <= 1'b0;
            bfm_active <= 1'b0;
            bfm_cnt    <= 0;
        end else if (!bfm_active) begin
            if (ctl_start && ctl_ready) begin
                bfm_active  <= 1'b1;
                bfm_cnt     <= 1;
                bfm_n_lat   <= bfm_n;
                bfm_ack_lat <= bfm_ack;
            end
        end else begin
            bfm_cnt <= bfm_cnt + 1;
            if (bfm_cnt == 2) ctl_ready <= 1'b0;
            else if (!bfm_stuck && bfm_cnt >= 2 + bfm_n_lat) begin
                ctl_ready  <= 1'b1;
                ctl_ack    <= bfm_ack_lat;
                bfm_active <= 1'b0;
            end
        end
    end

    // Values the DUT saw at each active edge.
    logic            e_reset, e_ready, e_ack;
    logic [N-1:0]    e_req;
    logic [8*N-1:0]  e_addr;
    logic [16*N-1:0] e_data;
    always @(posedge clk) begin
        e_reset <= reset;
        e_req   <= req;
        e_ready <= ctl_ready;
        e_ack   <= ctl_ack;
        e_addr  <= req_dev_addr;
        e_data  <= req_reg_data;
    end

    // Transaction-level reference: phase of the current transfer and held results.
    typedef enum int {M_IDLE, M_LAUNCH, M_BUSY, M_WAITDONE, M_FIN} mph_e;
    mph_e        mph;
    int          m_last, m_owner, m_w;
    logic [7:0]  m_addr;
    logic [15:0] m_data;
    logic        m_ack, m_err, mon_on;
    logic [N-1:0] exp_grant;

    always @(negedge clk) begin
        if (mon_on) begin
            if (e_reset) begin
                mph = M_IDLE; m_last = N - 1; m_owner = 0; m_ack = 1'b0; m_err = 1'b0; m_w = 0;
            end else begin
                case (mph)
                    M_IDLE: if (e_req != '0 && e_ready) begin
                        m_owner = rr_pick(e_req, m_last);
                        m_addr  = e_addr[8*m_owner +: 8];
                        m_data  = e_data[16*m_owner +: 16];
                        mph     = M_LAUNCH;
                    end
                    M_LAUNCH: begin mph = M_BUSY; m_w = 0; end
                    M_BUSY, M_WAITDONE: begin
                        m_w++;
                        if (WD_EN && m_w == TO) begin
                            mph = M_FIN; m_ack = 1'b0; m_err = 1'b1;
                        end else if (mph == M_BUSY && !e_ready) begin
                            mph = M_WAITDONE;
                        end else if (mph == M_WAITDONE && e_ready) begin
                            mph = M_FIN; m_ack = e_ack; m_err = 1'b0;
                        end
                    end
                    M_FIN: begin mph = M_IDLE; m_last = m_owner; end
                    default: mph = M_IDLE;
                endcase
            end
            exp_grant = (mph == M_IDLE) ? '0 : ({{(N-1){1'b0}}, 1'b1} << m_owner);
            chk("grant", 32'(grant), 32'(exp_grant));
            chk("done", 32'(done), (mph == M_FIN) ? 32'(exp_grant) : 32'd0);
            chk("ctl_start", 32'(ctl_start), 32'(mph == M_BUSY));
            chk("busy", 32'(busy), 32'(mph != M_IDLE));
            chk("ack_out", 32'(ack_out), 32'(m_ack));
            chk("err_out", 32'(err_out), 32'(m_err));
            if (mph != M_IDLE) begin
                chk("ctl_dev_addr", 32'(ctl_dev_addr), 32'(m_addr));
                chk("ctl_reg_data", 32'(ctl_reg_data), 32'(m_data));
            end
            if (e_reset) begin
                chk("reset_addr", 32'(ctl_dev_addr), 32'd0);
                chk("reset_data", 32'(ctl_reg_data), 32'd0);
            end
        end
    end

    task automatic step(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic apply_reset();
        reset = 1'b1; req = '0;
        step(2);
        reset = 1'b0;
        step(1);
    endtask

    task automatic wait_done(input int bound);
        logic ok;
        ok = 1'b0;
        for (int c = 0; c < bound; c++) begin
            step(1);
            if (done != '0) begin ok = 1'b1; break; end
        end
        chk("wait_done_in_time", 32'(ok), 32'd1);
    endtask

    task automatic wait_grant(input int bound);
        logic ok;
        ok = 1'b0;
        for (int c = 0; c < bound; c++) begin
            step(1);
            if (grant != '0) begin ok = 1'b1; break; end
        end
        chk("wait_grant_in_time", 32'(ok), 32'd1);
    endtask

    typedef struct {
        logic [N-1:0] req;
        int           n;
        logic         ack;
        logic [N-1:0] g;
        logic [7:0]   a;
        logic [15:0]  d;
    } vec_t;
    vec_t tbl [10];
    logic [N-1:0] rr_order [4];

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        tbl[0] = '{3'b001, 20, 1'b1, 3'b001, 8'h72, 16'h9803};
        tbl[1] = '{3'b111,  3, 1'b1, 3'b010, 8'h34, 16'h2211};
        tbl[2] = '{3'b111,  4, 1'b1, 3'b100, 8'h1A, 16'hBEEF};
        tbl[3] = '{3'b111,  2, 1'b1, 3'b001, 8'h72, 16'h9803};
        tbl[4] = '{3'b101,  5, 1'b0, 3'b100, 8'h1A, 16'hBEEF};
        tbl[5] = '{3'b011,  3, 1'b1, 3'b001, 8'h72, 16'h9803};
        tbl[6] = '{3'b110,  2, 1'b1, 3'b010, 8'h34, 16'h2211};
        tbl[7] = '{3'b010,  1, 1'b1, 3'b010, 8'h34, 16'h2211};
        tbl[8] = '{3'b100,  6, 1'b0, 3'b100, 8'h1A, 16'hBEEF};
        tbl[9] = '{3'b001,  2, 1'b1, 3'b001, 8'h72, 16'h9803};
        rr_order = '{3'b001, 3'b010, 3'b100, 3'b001};

        mon_on = 1'b0; reset = 1'b1; req = '0; bfm_stuck = 1'b0; bfm_n = 2; bfm_ack = 1'b1;
        req_dev_addr = {8'h1A, 8'h34, 8'h72};
        req_reg_data = {16'hBEEF, 16'h2211, 16'h9803};
        step(1);
        mon_on = 1'b1;
        step(1);
        reset = 1'b0;
        step(1);

        // Directed table: one full transaction per row, pointer carried across rows.
        for (int i = 0; i < 10; i++) begin
            bfm_n = tbl[i].n; bfm_ack = tbl[i].ack; req = tbl[i].req;
            wait_done(200);
            chk("tbl_done", 32'(done), 32'(tbl[i].g));
            chk("tbl_grant", 32'(grant), 32'(tbl[i].g));
            chk("tbl_ack", 32'(ack_out), 32'(tbl[i].ack));
            chk("tbl_err", 32'(err_out), 32'd0);
            chk("tbl_addr", 32'(ctl_dev_addr), 32'(tbl[i].a));
            chk("tbl_data", 32'(ctl_reg_data), 32'(tbl[i].d));
            req = '0;
            step(2);
        end

        // All requesters held from reset: fair rotation starting at requester 0.
        apply_reset();
        bfm_n = 2; bfm_ack = 1'b1; req = 3'b111;
        for (int k = 0; k < 4; k++) begin
            wait_grant(100);
            chk("rr_order", 32'(grant), 32'(rr_order[k]));
            wait_done(100);
            chk("rr_done", 32'(done), 32'(rr_order[k]));
            step(1);
        end
        req = '0;
        step(3);

        // Latched data immune to a requester change after grant.
        bfm_n = 8; req = 3'b001;
        wait_grant(50);
        step(1);
        req_reg_data[15:0] = 16'h1470;
        for (int c = 0; c < 100; c++) begin
            chk("latched_data", 32'(ctl_reg_data), 32'h9803);
            if (done != '0) break;
            step(1);
        end
        req = '0;
        req_reg_data[15:0] = 16'h9803;
        step(2);

        // Reset while waiting for the controller to finish.
        bfm_n = 20; req = 3'b001;
        wait_grant(50);
        step(1);
        for (int c = 0; c < 50 && ctl_start; c++) step(1);
        chk("in_wait_done", 32'(ctl_start), 32'd0);
        reset = 1'b1; req = '0;
        step(1);
        chk("rst_grant", 32'(grant), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_start", 32'(ctl_start), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        reset = 1'b0; bfm_n = 3; req = 3'b011;
        wait_grant(50);
        chk("post_rst_grant", 32'(grant), 32'b001);
        wait_done(100);
        req = '0;
        step(2);

        // Controller stuck busy.
        bfm_stuck = 1'b1; req = 3'b001;
        wait_grant(50);
        req = '0;
        step(1);
`ifdef I2C_ARB_TIMEOUT_EN
        begin
            int c;
            c = 0;
            for (int k = 0; k < 200; k++) begin
                step(1); c++;
                if (done != '0) break;
            end
            chk("wd_latency", 32'(c), 32'd64);
            chk("wd_err", 32'(err_out), 32'd1);
            chk("wd_ack", 32'(ack_out), 32'd0);
            step(2);
            req = 3'b010;
            step(5);
            chk("ready_gate", 32'(grant), 32'd0);
        end
`else
        begin
            logic saw;
            saw = 1'b0;
            for (int k = 0; k < 100; k++) begin
                step(1);
                if (done != '0) saw = 1'b1;
            end
            chk("stuck_no_done", 32'(saw), 32'd0);
            chk("stuck_busy", 32'(busy), 32'd1);
        end
`endif
        apply_reset();
        bfm_stuck = 1'b0;

        // Random traffic against the reference model.
        for (int c = 0; c < 3000; c++) begin
            bfm_n   = $urandom_range(1, 6);
            bfm_ack = ($urandom_range(0, 3) != 0);
            for (int i = 0; i < N; i++) begin
                if (done[i]) begin
                    req[i] = 1'b0;
                end else if (!req[i] && $urandom_range(0, 3) == 0) begin
                    req[i] = 1'b1;
                    req_dev_addr[8*i +: 8]   = 8'($urandom);
                    req_reg_data[16*i +: 16] = 16'($urandom);
                end else if ($urandom_range(0, 15) == 0) begin
                    req_reg_data[16*i +: 16] = 16'($urandom);
                end
            end
            step(1);
        end
        req = '0;
        for (int c = 0; c < 200 && busy; c++) step(1);
        chk("drain_idle", 32'(busy), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
